// File: rtl/neg_arb_pkg.sv
// neg_arb_pkg: shared state encoding and sizing constants for the negation arbiter
package neg_arb_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} neg_arb_state_t;
   localparam int ID_W = 1;
   localparam int NUM_REQ = 2;
endpackage

// File: rtl/inversor.sv
// inversor: two's-complement negator with a carry-out bit above the N-bit result
module inversor #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   output logic [N:0]   y
);
   assign y = {1'b0, ~a} + (N+1)'(1);
endmodule

// File: rtl/neg_arbiter.sv
// neg_arbiter: round-robin arbiter sequencing two requesters onto one shared negator
module neg_arbiter
   import neg_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [N-1:0]       a0,
   input  logic [N-1:0]       a1,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busy,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [N-1:0]       result,
   output logic [ID_W-1:0]    res_id,
   output logic               ovf
);
   neg_arb_state_t  state;
   logic [N-1:0]    op_q;
   logic [N-1:0]    neg;
   logic            unused_carry;
   logic [ID_W-1:0] last_id;
   logic [ID_W-1:0] win;
   inversor #(.N(N)) u_inv (.a(op_q), .y({unused_carry, neg}));
   // a tie goes to whoever was not served last
   assign win = (req == 2'b11) ? ~last_id : req[1];
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         result    <= '0;
         res_id    <= '0;
         ovf       <= 1'b0;
         last_id   <= 1'b1;
      end else begin
         case (state)
            IDLE: if (|req) begin
               op_q   <= win ? a1 : a0;
               res_id <= win;
               gnt    <= win ? 2'b10 : 2'b01;
               busy   <= 1'b1;
               state  <= CALC;
            end
            CALC: begin
               gnt       <= '0;
               result    <= neg;
               // only the most-negative value negates to a value that is still negative
               ovf       <= op_q[N-1] & neg[N-1];
               last_id   <= res_id;
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (res_ready) begin
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_neg_arbiter.sv
// tb_neg_arbiter: directed stimulus checked every cycle against an arithmetic model, plus literal pins
module tb_neg_arbiter;
   logic       clk, rst, ready, ready1, b0, b1;
   logic [1:0] req, req1, gnt, gnt1;
   logic [3:0] a0, a1, result;
   logic       busy, valid, res_id, ovf;
   logic       busy1, valid1, res_id1, ovf1, result1;
   int checks = 0, failures = 0;
   int ph, m_last, m_id, m_op, m_res, m_gnt, m_ovf, w;
   bit started = 0;
   int gcount, vcount;

   neg_arbiter #(.N(4)) dut (
      .clk(clk), .rst(rst), .req(req), .a0(a0), .a1(a1), .gnt(gnt), .busy(busy),
      .res_valid(valid), .res_ready(ready), .result(result), .res_id(res_id), .ovf(ovf));
   neg_arbiter #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .a0(b0), .a1(b1), .gnt(gnt1), .busy(busy1),
      .res_valid(valid1), .res_ready(ready1), .result(result1), .res_id(res_id1), .ovf(ovf1));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // model: IDLE=0, CALC=1, DONE=2; result is (2^4 - a) mod 2^4
   always @(posedge clk) begin
      if (rst) begin
         ph = 0; m_gnt = 0; m_res = 0; m_id = 0; m_ovf = 0; m_last = 1; m_op = 0;
         started = 1;
      end else if (ph == 0) begin
         if (req != 0) begin
            w = (req == 2'b11) ? 1 - m_last : (req == 2'b10 ? 1 : 0);
            m_id = w;
            m_op = w ? int'(a1) : int'(a0);
            m_gnt = 1 << w;
            ph = 1;
         end
      end else if (ph == 1) begin
         m_gnt = 0;
         m_res = (16 - m_op) % 16;
         m_ovf = (m_op == 8) ? 1 : 0;
         m_last = m_id;
         ph = 2;
      end else if (ready) ph = 0;
   end

   always @(negedge clk) if (started) begin
      check("gnt", int'(gnt), m_gnt);
      check("busy", int'(busy), ph != 0 ? 1 : 0);
      check("res_valid", int'(valid), ph == 2 ? 1 : 0);
      check("result", int'(result), m_res);
      check("ovf", int'(ovf), m_ovf);
      if (ph != 0) check("res_id", int'(res_id), m_id);
   end

   initial begin
      rst = 1; req = 0; a0 = 0; a1 = 0; ready = 1;
      req1 = 0; b0 = 0; b1 = 0; ready1 = 1;
      cyc(2);
      check("rst_gnt", int'(gnt), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_result", int'(result), 0);
      check("rst_id", int'(res_id), 0);
      rst = 0;
      req = 2'b01; a0 = 4'b0011;
      cyc(1); check("t1_gnt", int'(gnt), 1); req = 0;
      cyc(1);
      check("t1_valid", int'(valid), 1);
      check("t1_result", int'(result), 4'b1101);
      check("t1_id", int'(res_id), 0);
      check("t1_ovf", int'(ovf), 0);
      cyc(1);
      rst = 1; cyc(1); rst = 0;
      req = 2'b11; a0 = 4'b0001; a1 = 4'b0010;
      cyc(1); check("tie1_gnt", int'(gnt), 1); req = 2'b10;
      cyc(1); check("tie1_result", int'(result), 4'b1111); check("tie1_id", int'(res_id), 0);
      cyc(2); check("tie2_gnt", int'(gnt), 2); req = 2'b11;
      cyc(1); check("tie2_result", int'(result), 4'b1110); check("tie2_id", int'(res_id), 1);
      cyc(2); check("tie3_gnt", int'(gnt), 1); req = 0;
      cyc(2);
      req = 2'b01; a0 = 4'b1000;
      cyc(1); req = 0;
      cyc(1); check("min_result", int'(result), 4'b1000); check("min_ovf", int'(ovf), 1);
      cyc(1);
      req = 2'b01; a0 = 4'b0000;
      cyc(1); req = 0;
      cyc(1); check("zero_result", int'(result), 0); check("zero_ovf", int'(ovf), 0);
      cyc(1);
      ready = 0; req = 2'b01; a0 = 4'b0101; a1 = 4'b0111;
      cyc(1); req = 2'b10;
      cyc(1); check("bp_result", int'(result), 4'b1011);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("bp_hold_valid", int'(valid), 1);
         check("bp_hold_result", int'(result), 4'b1011);
         check("bp_hold_id", int'(res_id), 0);
         check("bp_hold_gnt", int'(gnt), 0);
      end
      ready = 1;
      cyc(1); check("bp_idle_valid", int'(valid), 0); check("bp_idle_gnt", int'(gnt), 0);
      cyc(1); check("bp_gnt", int'(gnt), 2); req = 0;
      cyc(3);
      req = 2'b01; a0 = 4'b0011;
      cyc(1); rst = 1; req = 0;
      cyc(1);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_valid", int'(valid), 0);
      check("rst_mid_gnt", int'(gnt), 0);
      rst = 0;
      cyc(1); check("rst_mid_novalid", int'(valid), 0);
      req = 2'b11;
      cyc(1); check("rst_tie_gnt", int'(gnt), 1); req = 0;
      cyc(2);
      req = 2'b01; a0 = 4'b0110; gcount = 0; vcount = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(1);
         gcount += int'(gnt[0]);
         vcount += int'(valid);
      end
      check("held_gnt_count", gcount, 3);
      check("held_valid_count", vcount, 3);
      req = 0;
      cyc(3);
      req1 = 2'b01; b0 = 1'b1;
      cyc(1); check("n1_gnt", int'(gnt1), 1); req1 = 0;
      cyc(1);
      check("n1_valid", int'(valid1), 1);
      check("n1_result", int'(result1), 1);
      check("n1_ovf", int'(ovf1), 1);
      check("n1_id", int'(res_id1), 0);
      cyc(1); check("n1_busy", int'(busy1), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
